// File: rtl/stack_sequencer.sv
// Multi-cycle stack sequencer for CALL, RET, interrupt entry and RTI.
// Owns the stack pointer and the stack side of the data-memory port, and freezes the pipeline while busy.
module stack_sequencer #(
  parameter int                      DATA_W     = 16,
  parameter int                      ADDR_W     = 12,
  parameter logic [ADDR_W-1:0]       SP_RESET   = ADDR_W'(2**ADDR_W-1),
  parameter logic [2*DATA_W-1:0]     INT_VECTOR = 32'h0000_0020,
  parameter int                      CCR_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  call_req,
  input  logic                  ret_req,
  input  logic                  rti_req,
  input  logic                  intr,
  input  logic                  pipe_busy,
  input  logic [2*DATA_W-1:0]   pc_in,
  input  logic [2*DATA_W-1:0]   call_target,
  input  logic [CCR_W-1:0]      ccr_in,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_W-1:0]     sp_out,
  output logic                  freeze_pc,
  output logic                  freeze_cu,
  output logic                  pc_load,
  output logic [2*DATA_W-1:0]   pc_out,
  output logic                  ccr_load,
  output logic [CCR_W-1:0]      ccr_out,
  output logic                  intr_ack,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE, INT_WAIT, PUSH_LO, PUSH_HI, PUSH_CCR, LOAD_PC,
    POP_CCR, POP_HI, POP_LO, POP_END
  } state_t;

  localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SP_TWO = ADDR_W'(2);

  state_t                state;
  logic [ADDR_W-1:0]     sp;
  logic                  int_pending;
  logic                  is_int;
  logic [2*DATA_W-1:0]   pc_lat;
  logic [2*DATA_W-1:0]   tgt_lat;
  logic [CCR_W-1:0]      ccr_lat;
  logic [DATA_W-1:0]     hi_q;
  logic [2*DATA_W-1:0]   pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sp          <= SP_RESET;
      int_pending <= 1'b0;
      is_int      <= 1'b0;
      pc_lat      <= '0;
      tgt_lat     <= '0;
      ccr_lat     <= '0;
      hi_q        <= '0;
      pc_q        <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      pc_load     <= 1'b0;
      ccr_load    <= 1'b0;
      intr_ack    <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      pc_load  <= 1'b0;
      ccr_load <= 1'b0;
      intr_ack <= 1'b0;
      if (intr) int_pending <= 1'b1;
      // Outputs are registered on entry to the state that presents them.
      case (state)
        IDLE: begin
          if (rti_req || ret_req || call_req || int_pending) begin
            pc_lat  <= pc_in;
            tgt_lat <= call_target;
            ccr_lat <= ccr_in;
          end
          if (rti_req) begin
            state    <= POP_CCR;
            mem_re   <= 1'b1;
            mem_addr <= sp + SP_ONE;
          end else if (ret_req) begin
            state    <= POP_HI;
            mem_re   <= 1'b1;
            mem_addr <= sp + SP_ONE;
          end else if (call_req) begin
            state     <= PUSH_LO;
            is_int    <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= sp;
            mem_wdata <= pc_in[DATA_W-1:0];
          end else if (int_pending) begin
            state       <= INT_WAIT;
            is_int      <= 1'b1;
            intr_ack    <= 1'b1;
            int_pending <= 1'b0;
          end
        end
        INT_WAIT: begin
          if (!pipe_busy) begin
            state     <= PUSH_LO;
            mem_we    <= 1'b1;
            mem_addr  <= sp;
            mem_wdata <= pc_lat[DATA_W-1:0];
          end
        end
        PUSH_LO: begin
          state     <= PUSH_HI;
          sp        <= sp - SP_ONE;
          mem_we    <= 1'b1;
          mem_addr  <= sp - SP_ONE;
          mem_wdata <= pc_lat[2*DATA_W-1:DATA_W];
        end
        PUSH_HI: begin
          sp <= sp - SP_ONE;
          if (is_int) begin
            state     <= PUSH_CCR;
            mem_we    <= 1'b1;
            mem_addr  <= sp - SP_ONE;
            mem_wdata <= {{(DATA_W-CCR_W){1'b0}}, ccr_lat};
          end else begin
            state   <= LOAD_PC;
            pc_load <= 1'b1;
            pc_q    <= tgt_lat;
          end
        end
        PUSH_CCR: begin
          state   <= LOAD_PC;
          sp      <= sp - SP_ONE;
          pc_load <= 1'b1;
          pc_q    <= INT_VECTOR;
        end
        LOAD_PC: state <= IDLE;
        POP_CCR: begin
          state    <= POP_HI;
          sp       <= sp + SP_ONE;
          mem_re   <= 1'b1;
          mem_addr <= sp + SP_TWO;
          ccr_load <= 1'b1;
        end
        POP_HI: begin
          state    <= POP_LO;
          sp       <= sp + SP_ONE;
          mem_re   <= 1'b1;
          mem_addr <= sp + SP_TWO;
        end
        POP_LO: begin
          state   <= POP_END;
          sp      <= sp + SP_ONE;
          hi_q    <= mem_rdata;
          pc_load <= 1'b1;
        end
        POP_END: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Popped words arrive a cycle after the read, so reloads forward mem_rdata directly.
  assign pc_out    = (state == POP_END) ? {hi_q, mem_rdata} : pc_q;
  assign ccr_out   = ccr_load ? mem_rdata[CCR_W-1:0] : '0;
  assign sp_out    = sp;
  assign busy      = (state != IDLE);
  assign freeze_pc = busy;
  assign freeze_cu = busy && (state != INT_WAIT);

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized scoreboard bench for stack_sequencer: an abstract stack model predicts memory, reload and ack events.
// A negedge monitor pops predictions whenever the DUT strobes, plus busy and drain-window run lengths.
module tb_stack_sequencer;
  localparam int EV_WR = 0, EV_RD = 1, EV_PC = 2, EV_CCR = 3, EV_ACK = 4;
  localparam int OP_CALL = 0, OP_RET = 1, OP_RTI = 2, OP_INT = 3, OP_CALL_INT = 4;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        call_req = 1'b0, ret_req = 1'b0, rti_req = 1'b0, intr = 1'b0, pipe_busy = 1'b0;
  logic [31:0] pc_in = '0, call_target = '0;
  logic [3:0]  ccr_in = '0;
  logic [15:0] mem_rdata;
  logic [11:0] mem_addr, sp_out;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re, freeze_pc, freeze_cu, pc_load, ccr_load, intr_ack, busy;
  logic [31:0] pc_out;
  logic [3:0]  ccr_out;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic ram_clr = 1'b0;

  ev_t exp_q[$];
  int  busy_q[$];
  int  wait_q[$];

  logic [15:0] ram [0:4095];
  logic [15:0] rd_q = '0;
  logic [15:0] model_mem [0:4095];
  logic [11:0] model_sp;

  always #5 clk = ~clk;

  stack_sequencer dut (
    .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req), .rti_req(rti_req),
    .intr(intr), .pipe_busy(pipe_busy), .pc_in(pc_in), .call_target(call_target),
    .ccr_in(ccr_in), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .sp_out(sp_out), .freeze_pc(freeze_pc),
    .freeze_cu(freeze_cu), .pc_load(pc_load), .pc_out(pc_out), .ccr_load(ccr_load),
    .ccr_out(ccr_out), .intr_ack(intr_ack), .busy(busy)
  );

  // Synchronous-read data memory: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) rd_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = rd_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  task automatic take(input int kind, input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual kind=%0d addr=%h data=%h expected none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== a || e.data !== d) begin
        errors++;
        $display("FAIL event actual kind=%0d addr=%h data=%h expected kind=%0d addr=%h data=%h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  int brun = 0;
  int wrun = 0;
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (intr_ack) take(EV_ACK, 12'h0, 32'h0);
      if (ccr_load) take(EV_CCR, 12'h0, {28'h0, ccr_out});
      if (mem_we)   take(EV_WR, mem_addr, {16'h0, mem_wdata});
      if (mem_re)   take(EV_RD, mem_addr, 32'h0);
      if (pc_load)  take(EV_PC, sp_out, pc_out);
      if (mem_we || mem_re) chk("we_re_exclusive", {31'h0, mem_we & mem_re}, 32'h0);
      if (busy) brun++;
      else if (brun > 0) begin
        if (busy_q.size() == 0) chk("busy_len_unexpected", brun, 0);
        else chk("busy_len", brun, busy_q.pop_front());
        brun = 0;
      end
      if (freeze_pc && !freeze_cu) wrun++;
      else if (wrun > 0) begin
        if (wait_q.size() == 0) chk("int_wait_unexpected", wrun, 0);
        else chk("int_wait_len", wrun, wait_q.pop_front());
        wrun = 0;
      end
    end
  end

  // Abstract stack model: push writes at SP then decrements; pop increments then reads.
  function automatic void m_push(input logic [15:0] w);
    model_mem[model_sp] = w;
    exp_q.push_back('{EV_WR, model_sp, {16'h0, w}});
    model_sp = model_sp - 12'd1;
  endfunction

  function automatic logic [15:0] m_pop();
    model_sp = model_sp + 12'd1;
    exp_q.push_back('{EV_RD, model_sp, 32'h0});
    return model_mem[model_sp];
  endfunction

  function automatic void predict(input int op, input logic [31:0] pc, input logic [31:0] tgt,
                                  input logic [3:0] ccr, input int nw);
    logic [15:0] hi, lo, c;
    int eff;
    eff = (nw < 1) ? 1 : nw;
    case (op)
      OP_CALL, OP_CALL_INT: begin
        m_push(pc[15:0]);
        m_push(pc[31:16]);
        exp_q.push_back('{EV_PC, model_sp, tgt});
        busy_q.push_back(3);
        if (op == OP_CALL_INT) begin
          exp_q.push_back('{EV_ACK, 12'h0, 32'h0});
          m_push(pc[15:0]);
          m_push(pc[31:16]);
          m_push({12'h0, ccr});
          exp_q.push_back('{EV_PC, model_sp, 32'h0000_0020});
          busy_q.push_back(5);
          wait_q.push_back(1);
        end
      end
      OP_RET: begin
        hi = m_pop();
        lo = m_pop();
        exp_q.push_back('{EV_PC, model_sp, {hi, lo}});
        busy_q.push_back(3);
      end
      OP_RTI: begin
        c = m_pop();
        exp_q.push_back('{EV_CCR, 12'h0, {28'h0, c[3:0]}});
        hi = m_pop();
        lo = m_pop();
        exp_q.push_back('{EV_PC, model_sp, {hi, lo}});
        busy_q.push_back(4);
      end
      default: begin
        exp_q.push_back('{EV_ACK, 12'h0, 32'h0});
        m_push(pc[15:0]);
        m_push(pc[31:16]);
        m_push({12'h0, ccr});
        exp_q.push_back('{EV_PC, model_sp, 32'h0000_0020});
        busy_q.push_back(eff + 4);
        wait_q.push_back(eff);
      end
    endcase
  endfunction

  task automatic wait_idle();
    int cnt = 0;
    int guard = 0;
    while (cnt < 4 && guard < 300) begin
      @(posedge clk); #1;
      if (!busy) cnt++; else cnt = 0;
      guard++;
    end
    if (guard >= 300) chk("idle_timeout", 32'h1, 32'h0);
  endtask

  task automatic run_op(input int op, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [3:0] ccr, input int nw);
    predict(op, pc, tgt, ccr, nw);
    @(posedge clk); #1;
    pc_in = pc; call_target = tgt; ccr_in = ccr;
    case (op)
      OP_CALL: call_req = 1'b1;
      OP_RET:  ret_req = 1'b1;
      OP_RTI:  rti_req = 1'b1;
      OP_INT:  intr = 1'b1;
      default: begin call_req = 1'b1; intr = 1'b1; end
    endcase
    @(posedge clk); #1;
    call_req = 1'b0; ret_req = 1'b0; rti_req = 1'b0; intr = 1'b0;
    if (op == OP_INT && nw > 0) begin
      pipe_busy = 1'b1;
      repeat (nw) @(posedge clk);
      #1 pipe_busy = 1'b0;
    end
    wait_idle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_strobes"}, {24'h0, mem_we, mem_re, pc_load, ccr_load, intr_ack, busy, freeze_pc, freeze_cu}, 32'h0);
    chk({tag, "_mem_addr"}, {20'h0, mem_addr}, 32'h0);
    chk({tag, "_mem_wdata"}, {16'h0, mem_wdata}, 32'h0);
    chk({tag, "_pc_out"}, pc_out, 32'h0);
    chk({tag, "_ccr_out"}, {28'h0, ccr_out}, 32'h0);
    chk({tag, "_sp_out"}, {20'h0, sp_out}, 32'h0000_0FFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_load;
    #12;
    chk_reset_outputs("reset_initial");
    @(posedge clk); #1 rst = 1'b1;
    // Start a CALL and abort it with an asynchronous reset in the middle.
    @(posedge clk); #1;
    pc_in = 32'h0001_2345; call_target = 32'h0000_0100; call_req = 1'b1;
    @(posedge clk); #1 call_req = 1'b0;
    @(posedge clk); #1;
    chk("midcall_busy", {31'h0, busy}, 32'h1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("reset_midcall");
    @(posedge clk); #1 rst = 1'b1;
    saw_load = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (pc_load) saw_load = 1'b1;
    end
    chk("post_reset_busy", {31'h0, busy}, 32'h0);
    chk("post_reset_no_pc_load", {31'h0, saw_load}, 32'h0);
    chk("post_reset_sp", {20'h0, sp_out}, 32'h0000_0FFF);

    ram_clr = 1'b1;
    @(posedge clk); #1 ram_clr = 1'b0;
    for (int i = 0; i < 4096; i++) model_mem[i] = 16'h0;
    model_sp = 12'hFFF;
    mon_en = 1'b1;

    // Pop wraps FFF->000->001, then pushes wrap 000->FFF.
    run_op(OP_RET, 32'h0, 32'h0, 4'h0, 0);
    run_op(OP_CALL, 32'hDEAD_BEEF, 32'h0000_0400, 4'h0, 0);
    chk("wrap_sp", {20'h0, sp_out}, 32'h0000_0FFF);
    run_op(OP_CALL, 32'h0001_2345, 32'h0000_0100, 4'h3, 0);
    run_op(OP_RET, 32'h0, 32'h0, 4'h0, 0);
    run_op(OP_INT, 32'h0000_0050, 32'h0, 4'b1010, 2);
    run_op(OP_RTI, 32'h0, 32'h0, 4'h0, 0);
    run_op(OP_CALL_INT, 32'h0000_1234, 32'h0000_0800, 4'h5, 0);
    run_op(OP_RTI, 32'h0, 32'h0, 4'h0, 0);
    run_op(OP_RET, 32'h0, 32'h0, 4'h0, 0);

    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(0, 4)), $urandom, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sp_final", {20'h0, sp_out}, {20'h0, model_sp});
    chk("events_drained", exp_q.size(), 32'h0);
    chk("busy_runs_drained", busy_q.size(), 32'h0);
    chk("wait_runs_drained", wait_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Single controller for all multi-cycle stack operations: CALL, RET, INT entry and RTI.
- Owns the stack pointer and drives the stack side of the data-memory port.
- While a sequence runs, it freezes PC and control, splits the 32-bit PC into two 16-bit stack words, and issues the final PC/CCR reload.
- Sits beside the decode/control logic; the memory-stage mux selects its port whenever busy=1.

Parameters:
- DATA_W, 16, memory word width; PC is 2*DATA_W.
- ADDR_W, 12, data-memory address width.
- SP_RESET, 2**ADDR_W-1, stack pointer value after reset.
- INT_VECTOR, 32'h0000_0020, PC loaded on interrupt entry.
- CCR_W, 4, condition-code register width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- call_req  in  1  decoded CALL, single-cycle pulse.
- ret_req  in  1  decoded RET, single-cycle pulse.
- rti_req  in  1  decoded RTI, single-cycle pulse.
- intr  in  1  external interrupt, level or pulse.
- pipe_busy  in  1  LDM second word or load-use stall in flight.
- pc_in  in  32  return PC presented with request.
- call_target  in  32  CALL destination.
- ccr_in  in  CCR_W  current flags.
- mem_rdata  in  DATA_W  memory read data, valid cycle after mem_re.
- mem_addr  out  ADDR_W  stack access address.
- mem_wdata  out  DATA_W  push data.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- sp_out  out  ADDR_W  current SP.
- freeze_pc  out  1  hold PC.
- freeze_cu  out  1  force NOP into decode.
- pc_load  out  1  one-cycle PC overwrite strobe.
- pc_out  out  32  PC value for pc_load.
- ccr_load  out  1  one-cycle CCR overwrite strobe.
- ccr_out  out  CCR_W  CCR value for ccr_load.
- intr_ack  out  1  one-cycle pulse when interrupt is accepted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE, SP=SP_RESET, int_pending=0.
- All strobes, freezes, busy and intr_ack are 0; pc_out, ccr_out, mem_addr and mem_wdata are 0.
- Reset mid-sequence aborts the sequence immediately, with no partial pc_load.

Stack convention:
- Push: write at SP, then SP<=SP-1.
- Pop: SP<=SP+1, read at SP+1.
- SP wraps modulo 2**ADDR_W; no overflow flag.

Interrupt latch:
- intr=1 sets int_pending; it is cleared when intr_ack pulses.

IDLE arbitration (one per cycle), priority rti_req > ret_req > call_req > int_pending:
- Request inputs are ignored outside IDLE.
- On acceptance, latch pc_in, call_target and ccr_in.
- int_pending is only taken if no instruction request is present that cycle.

Sequences (one state per cycle; freeze_pc=freeze_cu=1 in every state except IDLE and INT_WAIT):
- CALL: PUSH_LO (write pc[15:0]) -> PUSH_HI (write pc[31:16]) -> LOAD_PC (pc_load=1, pc_out=call_target) -> IDLE. Three cycles.
- INT:
  - Accept pulses intr_ack and enters INT_WAIT. INT_WAIT has freeze_pc=1, freeze_cu=0 so the pipeline drains, and it holds while pipe_busy=1.
  - Then PUSH_LO -> PUSH_HI -> PUSH_CCR (write zero-extended ccr) -> LOAD_PC (pc_out=INT_VECTOR) -> IDLE.
  - The return PC is pc_in latched at accept.
- RET: POP_HI (mem_re, addr SP+1) -> POP_LO (capture hi, mem_re) -> POP_END (pc_load=1, pc_out={hi, mem_rdata}) -> IDLE.
- RTI: POP_CCR (mem_re) -> POP_HI (ccr_load=1, ccr_out=mem_rdata[CCR_W-1:0], mem_re) -> POP_LO -> POP_END as RET.

Strobe rules:
- mem_we and mem_re are never both high.
- pc_load and ccr_load last exactly one cycle.
- A new request may be accepted in the cycle after the return to IDLE.
- intr arriving mid-sequence is latched and taken after the sequence if no instruction request competes.

Test Plan:
- Reset: rst=0 mid-CALL -> outputs 0, sp_out=0xFFF; after release, busy=0.
- CALL with pc_in=0x0001_2345, call_target=0x0000_0100:
  - mem[0xFFF]=0x2345, then mem[0xFFE]=0x0001.
  - Cycle 3: pc_load=1, pc_out=0x100, sp_out=0xFFD.
- RET following that CALL:
  - Reads 0xFFE then 0xFFF.
  - pc_load=1 with pc_out=0x0001_2345; sp_out=0xFFF; busy for 3 cycles.
- Interrupt with pipe_busy=1 for 2 cycles, pc_in=0x0000_0050, ccr_in=4'b1010:
  - intr_ack once; 2 INT_WAIT cycles.
  - Writes 0x0050@0xFFF, 0x0000@0xFFE, 0x000A@0xFFD.
  - pc_out=0x20; sp_out=0xFFC.
- RTI after interrupt:
  - ccr_load=1 with 4'b1010, then pc_load=1 with 0x0000_0050; sp_out=0xFFF.
- Simultaneous call_req and intr in IDLE:
  - CALL runs first; intr_ack is issued in the cycle after the return to IDLE.
  - SP wraps correctly when SP_RESET is forced to 0x000 and a push occurs: 0x000 -> 0xFFF.
